// File: rtl/press_classifier.sv
// Classifies conditioned button presses into short and long presses.
// Long presses can optionally auto-repeat the long pulse while the button stays held.
module press_classifier #(
  parameter int MIN_CYCLES    = 3,
  parameter int LONG_CYCLES   = 100,
  parameter int REPEAT_CYCLES = 0,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       button,
  output logic       short_pulse,
  output logic       long_pulse,
  output logic       held,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    PRESSED   = 2'b01,
    LONG_HELD = 2'b10,
    UNUSED    = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_CYCLES);
  localparam logic [CNT_W-1:0] LONG_C   = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] REPEAT_C = CNT_W'(REPEAT_CYCLES);
  localparam logic             REPEAT_EN = (REPEAT_CYCLES > 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             short_d, long_d;

  // Saturating increment keeps the counters from ever wrapping.
  function automatic logic [CNT_W-1:0] inc_sat(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) return v;
    else                    return v + CNT_W'(1);
  endfunction

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    short_d    = 1'b0;
    long_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (button) begin
          state_d    = PRESSED;
          hold_cnt_d = CNT_W'(1);
        end
      end
      PRESSED: begin
        if (button) begin
          hold_cnt_d = inc_sat(hold_cnt_q);
          if (hold_cnt_d == LONG_C) begin
            state_d   = LONG_HELD;
            long_d    = 1'b1;
            rep_cnt_d = '0;
          end
        end else begin
          short_d    = (hold_cnt_q >= MIN_C);
          state_d    = IDLE;
          hold_cnt_d = '0;
        end
      end
      LONG_HELD: begin
        // hold_cnt stays frozen at LONG_CYCLES here; only rep_cnt advances.
        if (button) begin
          if (REPEAT_EN) begin
            if (inc_sat(rep_cnt_q) == REPEAT_C) begin
              long_d    = 1'b1;
              rep_cnt_d = '0;
            end else begin
              rep_cnt_d = inc_sat(rep_cnt_q);
            end
          end
        end else begin
          state_d    = IDLE;
          hold_cnt_d = '0;
          rep_cnt_d  = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        hold_cnt_d = '0;
        rep_cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_cnt_q  <= '0;
      rep_cnt_q   <= '0;
      short_pulse <= 1'b0;
      long_pulse  <= 1'b0;
      held        <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      short_pulse <= short_d;
      long_pulse  <= long_d;
      held        <= (state_d != IDLE);
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_press_classifier.sv
// Bench for press_classifier: directed press scenarios plus randomized press
// trains, checked against a run-length reference model of press classification.
module tb_press_classifier;

  localparam int MIN  = 3;
  localparam int LONG = 10;
  localparam int REP  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       button = 1'b0;
  logic       short_pulse, long_pulse, held;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;

  // Reference model: length of the current run of high samples.
  int         run = 0;
  logic       e_short = 1'b0, e_long = 1'b0, e_held = 1'b0;
  logic [1:0] e_state = 2'b00;

  press_classifier #(
    .MIN_CYCLES(MIN), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .button(button),
    .short_pulse(short_pulse), .long_pulse(long_pulse),
    .held(held), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired: got timeout required completion");
    $fatal(1);
  end

  // Apply one button sample on the next rising edge and update the model; returns at the falling edge.
  task automatic drive(input logic b);
    button = b;
    @(posedge clk);
    e_short = 1'b0;
    e_long  = 1'b0;
    if (b) begin
      run++;
      if (run == LONG) e_long = 1'b1;
      else if (REP > 0 && run > LONG && ((run - LONG) % REP) == 0) e_long = 1'b1;
    end else begin
      if (run >= MIN && run < LONG) e_short = 1'b1;
      run = 0;
    end
    e_held  = (run > 0);
    e_state = (run == 0) ? 2'b00 : (run < LONG) ? 2'b01 : 2'b10;
    @(negedge clk);
  endtask

  task automatic model_reset();
    run = 0; e_short = 1'b0; e_long = 1'b0; e_held = 1'b0; e_state = 2'b00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; button = 1'b1;
    #1;
    checks++;
    if ({short_pulse, long_pulse, held, state_dbg} !== 5'b0) begin
      errors++;
      $display("FAIL reset_state got %b required %b", {short_pulse, long_pulse, held, state_dbg}, 5'b0);
    end
    @(negedge clk); @(negedge clk);
    checks++;
    if ({short_pulse, long_pulse, held, state_dbg} !== 5'b0) begin
      errors++;
      $display("FAIL reset_hold got %b required %b", {short_pulse, long_pulse, held, state_dbg}, 5'b0);
    end
    button = 1'b0;
    rst_n = 1'b1;
    model_reset();
    drive(1'b0);
    checks++;
    if ({short_pulse, long_pulse, held, state_dbg} !== {e_short, e_long, e_held, e_state}) begin
      errors++;
      $display("FAIL reset_release got %b required %b", {short_pulse, long_pulse, held, state_dbg}, {e_short, e_long, e_held, e_state});
    end
  endtask

  task automatic test_too_short();
    int pulses = 0;
    int held_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      drive(i < 2);
      checks++;
      if ({short_pulse, long_pulse, held, state_dbg} !== {e_short, e_long, e_held, e_state}) begin
        errors++;
        $display("FAIL too_short cyc%0d got %b required %b", i, {short_pulse, long_pulse, held, state_dbg}, {e_short, e_long, e_held, e_state});
      end
      pulses += int'(short_pulse) + int'(long_pulse);
      held_cycles += int'(held);
    end
    checks++;
    if (pulses != 0 || held_cycles != 2 || state_dbg !== 2'b00) begin
      errors++;
      $display("FAIL too_short_summary got pulses=%0d held=%0d state=%b required 0 2 00", pulses, held_cycles, state_dbg);
    end
  endtask

  task automatic test_short();
    int shorts = 0;
    int longs = 0;
    for (int i = 0; i < 8; i++) begin
      drive(i < 5);
      checks++;
      if ({short_pulse, long_pulse, held, state_dbg} !== {e_short, e_long, e_held, e_state}) begin
        errors++;
        $display("FAIL short cyc%0d got %b required %b", i, {short_pulse, long_pulse, held, state_dbg}, {e_short, e_long, e_held, e_state});
      end
      checks++;
      if (short_pulse !== (i == 5)) begin
        errors++;
        $display("FAIL short_timing cyc%0d got %b required %b", i, short_pulse, (i == 5));
      end
      shorts += int'(short_pulse);
      longs += int'(long_pulse);
    end
    checks++;
    if (shorts != 1 || longs != 0) begin
      errors++;
      $display("FAIL short_summary got shorts=%0d longs=%0d required 1 0", shorts, longs);
    end
  endtask

  task automatic test_threshold();
    int shorts;
    int longs;
    for (int len = 9; len <= 10; len++) begin
      shorts = 0;
      longs = 0;
      for (int i = 0; i < len + 3; i++) begin
        drive(i < len);
        checks++;
        if ({short_pulse, long_pulse, held, state_dbg} !== {e_short, e_long, e_held, e_state}) begin
          errors++;
          $display("FAIL threshold len%0d cyc%0d got %b required %b", len, i, {short_pulse, long_pulse, held, state_dbg}, {e_short, e_long, e_held, e_state});
        end
        checks++;
        if (long_pulse !== (len == 10 && i == 9)) begin
          errors++;
          $display("FAIL threshold_long len%0d cyc%0d got %b required %b", len, i, long_pulse, (len == 10 && i == 9));
        end
        shorts += int'(short_pulse);
        longs += int'(long_pulse);
      end
      checks++;
      if (shorts != (len == 9 ? 1 : 0) || longs != (len == 10 ? 1 : 0)) begin
        errors++;
        $display("FAIL threshold_summary len%0d got shorts=%0d longs=%0d required %0d %0d", len, shorts, longs, (len == 9 ? 1 : 0), (len == 10 ? 1 : 0));
      end
    end
  endtask

  task automatic test_repeat();
    int longs = 0;
    int shorts = 0;
    for (int i = 0; i < 23; i++) begin
      drive(i < 20);
      checks++;
      if ({short_pulse, long_pulse, held, state_dbg} !== {e_short, e_long, e_held, e_state}) begin
        errors++;
        $display("FAIL repeat cyc%0d got %b required %b", i, {short_pulse, long_pulse, held, state_dbg}, {e_short, e_long, e_held, e_state});
      end
      checks++;
      if (long_pulse !== (i == 9 || i == 13 || i == 17)) begin
        errors++;
        $display("FAIL repeat_tick cyc%0d got %b required %b", i, long_pulse, (i == 9 || i == 13 || i == 17));
      end
      longs += int'(long_pulse);
      shorts += int'(short_pulse);
    end
    checks++;
    if (longs != 3 || shorts != 0 || state_dbg !== 2'b00) begin
      errors++;
      $display("FAIL repeat_summary got longs=%0d shorts=%0d state=%b required 3 0 00", longs, shorts, state_dbg);
    end
  endtask

  task automatic test_reset_mid_press();
    int longs = 0;
    for (int i = 0; i < 7; i++) drive(1'b1);
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({short_pulse, long_pulse, held, state_dbg} !== 5'b0) begin
      errors++;
      $display("FAIL midreset_async got %b required %b", {short_pulse, long_pulse, held, state_dbg}, 5'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      drive(i < 12);
      checks++;
      if ({short_pulse, long_pulse, held, state_dbg} !== {e_short, e_long, e_held, e_state}) begin
        errors++;
        $display("FAIL midreset cyc%0d got %b required %b", i, {short_pulse, long_pulse, held, state_dbg}, {e_short, e_long, e_held, e_state});
      end
      checks++;
      if (long_pulse !== (i == 9) || short_pulse !== 1'b0) begin
        errors++;
        $display("FAIL midreset_pulse cyc%0d got long=%b short=%b required long=%b short=0", i, long_pulse, short_pulse, (i == 9));
      end
      longs += int'(long_pulse);
    end
    checks++;
    if (longs != 1) begin
      errors++;
      $display("FAIL midreset_summary got longs=%0d required 1", longs);
    end
  endtask

  task automatic test_back_to_back();
    int shorts = 0;
    for (int i = 0; i < 14; i++) begin
      drive((i < 5) || (i >= 6 && i < 11));
      checks++;
      if ({short_pulse, long_pulse, held, state_dbg} !== {e_short, e_long, e_held, e_state}) begin
        errors++;
        $display("FAIL back_to_back cyc%0d got %b required %b", i, {short_pulse, long_pulse, held, state_dbg}, {e_short, e_long, e_held, e_state});
      end
      checks++;
      if (short_pulse !== (i == 5 || i == 11)) begin
        errors++;
        $display("FAIL back_to_back_short cyc%0d got %b required %b", i, short_pulse, (i == 5 || i == 11));
      end
      shorts += int'(short_pulse);
    end
    checks++;
    if (shorts != 2 || state_dbg !== 2'b00 || held !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_summary got shorts=%0d state=%b held=%b required 2 00 0", shorts, state_dbg, held);
    end
  endtask

  task automatic test_random();
    int hi_len;
    int lo_len;
    for (int p = 0; p < 150; p++) begin
      hi_len = $urandom_range(1, 24);
      lo_len = $urandom_range(1, 3);
      for (int i = 0; i < hi_len + lo_len; i++) begin
        drive(i < hi_len);
        checks++;
        if ({short_pulse, long_pulse, held, state_dbg} !== {e_short, e_long, e_held, e_state}) begin
          errors++;
          $display("FAIL random p%0d cyc%0d got %b required %b", p, i, {short_pulse, long_pulse, held, state_dbg}, {e_short, e_long, e_held, e_state});
        end
        checks++;
        if (short_pulse === 1'b1 && long_pulse === 1'b1) begin
          errors++;
          $display("FAIL random_exclusive p%0d cyc%0d got short=1 long=1 required not both", p, i);
        end
      end
      if ($urandom_range(0, 19) == 0) begin
        button = 1'b1;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({short_pulse, long_pulse, held, state_dbg} !== 5'b0) begin
          errors++;
          $display("FAIL random_reset p%0d got %b required %b", p, {short_pulse, long_pulse, held, state_dbg}, 5'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_too_short();
    test_short();
    test_threshold();
    test_repeat();
    test_reset_mid_press();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
